// File: rtl/vector_operand_collector_pkg.sv
// Shared types and default sizes for the vector operand collector.
package vector_operand_collector_pkg;

  localparam int VOC_VREG_COUNT   = 256;
  localparam int VOC_NUM_ELEMENTS = 32;
  localparam int VOC_DATA_WIDTH   = 16;
  localparam int VOC_TAG_W        = 4;
  localparam int VOC_MAX_WAIT     = 4;

  localparam int AW = $clog2(VOC_VREG_COUNT);
  localparam int VW = VOC_NUM_ELEMENTS * VOC_DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } collector_state_t;

  // Bundle widths follow the package defaults above.
  typedef struct packed {
    logic [VW-1:0]        v1;
    logic [VW-1:0]        v2;
    logic [VW-1:0]        vmask;
    logic [AW-1:0]        vd;
    logic [VOC_TAG_W-1:0] tag;
  } operand_bundle_t;

  // Saturating increment for the 16-bit stall counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] x);
    return (x == 16'hFFFF) ? x : x + 16'd1;
  endfunction

endpackage

// File: rtl/vop_out_reg.sv
// Single-entry valid/ready register holding one operand bundle for execute.
module vop_out_reg
  import vector_operand_collector_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            load,
  input  operand_bundle_t load_bundle,
  input  logic            ready,
  output logic            valid,
  output operand_bundle_t bundle,
  output logic            free
);

  // A slot is free when empty or being drained this cycle.
  assign free = !valid || ready;

  // Occupancy: flush wins, then load, then drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

  // Payload only changes on a load, so it stays stable under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bundle <= '0;
    end else if (load && !flush) begin
      bundle <= load_bundle;
    end
  end

endmodule

// File: rtl/vector_operand_collector.sv
// Issue-side requester: latches one instruction, reads the banked vector
// register file (holding the request through stalls) and hands the operands
// to the execution lane through a valid/ready output register.
module vector_operand_collector
  import vector_operand_collector_pkg::*;
#(
  parameter  int VREG_COUNT   = VOC_VREG_COUNT,
  parameter  int NUM_ELEMENTS = VOC_NUM_ELEMENTS,
  parameter  int DATA_WIDTH   = VOC_DATA_WIDTH,
  parameter  int TAG_W        = VOC_TAG_W,
  parameter  int MAX_WAIT     = VOC_MAX_WAIT,
  localparam int A_W          = $clog2(VREG_COUNT),
  localparam int V_W          = NUM_ELEMENTS * DATA_WIDTH
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             iss_valid,
  output logic             iss_ready,
  input  logic [A_W-1:0]   iss_vs1,
  input  logic [A_W-1:0]   iss_vs2,
  input  logic [A_W-1:0]   iss_vd,
  input  logic             iss_vm,
  input  logic [TAG_W-1:0] iss_tag,
  input  logic             flush,
  output logic             rf_ren,
  output logic [A_W-1:0]   rf_vs1,
  output logic [A_W-1:0]   rf_vs2,
  output logic             rf_vm,
  input  logic             rf_ready,
  input  logic             rf_conflict,
  input  logic [V_W-1:0]   rf_v1,
  input  logic [V_W-1:0]   rf_v2,
  input  logic [V_W-1:0]   rf_vmask,
  output logic             ex_valid,
  input  logic             ex_ready,
  output logic [V_W-1:0]   ex_v1,
  output logic [V_W-1:0]   ex_v2,
  output logic [V_W-1:0]   ex_vmask,
  output logic [A_W-1:0]   ex_vd,
  output logic [TAG_W-1:0] ex_tag,
  output logic             timeout_err,
  output logic [15:0]      stall_cnt
);

  localparam int              WC_W      = $clog2(MAX_WAIT + 1);
  localparam logic [WC_W-1:0] WAIT_LIM  = WC_W'(MAX_WAIT);
  localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(MAX_WAIT - 1);

  collector_state_t  state;
  logic [A_W-1:0]    lat_vs1, lat_vs2, lat_vd;
  logic              lat_vm;
  logic [TAG_W-1:0]  lat_tag;
  logic [WC_W-1:0]   wait_cnt;
  operand_bundle_t   capture_bundle, hold_bundle, load_bundle, out_bundle;
  logic              out_free, load, capture;
  logic              unused_conflict;

  // A conflict is just another cycle without rf_ready; the flag itself
  // carries no extra meaning for the collector.
  assign unused_conflict = rf_conflict;

  assign iss_ready = nRST && !flush && (state == IDLE) && out_free;
  assign rf_ren    = (state == REQ);
  assign rf_vs1    = lat_vs1;
  assign rf_vs2    = lat_vs2;
  assign rf_vm     = rf_ren && lat_vm;

  assign capture = (state == REQ) && rf_ready && !flush;
  assign load    = !flush && out_free && (((state == REQ) && rf_ready) || (state == HOLD));

  // Operand substitution: register 0 reads as zero, unmasked ops get all-ones.
  always_comb begin
    capture_bundle.v1    = (lat_vs1 == '0) ? '0 : rf_v1;
    capture_bundle.v2    = (lat_vs2 == '0) ? '0 : rf_v2;
    capture_bundle.vmask = lat_vm ? rf_vmask : '1;
    capture_bundle.vd    = lat_vd;
    capture_bundle.tag   = lat_tag;
    load_bundle          = (state == HOLD) ? hold_bundle : capture_bundle;
  end

  // Control: issue latch, request/hold sequencing, stall accounting.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state       <= IDLE;
      lat_vs1     <= '0;
      lat_vs2     <= '0;
      lat_vd      <= '0;
      lat_vm      <= 1'b0;
      lat_tag     <= '0;
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
      stall_cnt   <= '0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (iss_valid && iss_ready) begin
            lat_vs1  <= iss_vs1;
            lat_vs2  <= iss_vs2;
            lat_vd   <= iss_vd;
            lat_vm   <= iss_vm;
            lat_tag  <= iss_tag;
            wait_cnt <= '0;
            state    <= REQ;
          end
        end
        REQ: begin
          if (rf_ready) begin
            state <= out_free ? IDLE : HOLD;
          end else begin
            stall_cnt <= sat_inc16(stall_cnt);
            if (wait_cnt != WAIT_LIM) wait_cnt <= wait_cnt + WC_W'(1);
            if (wait_cnt >= WAIT_LAST) timeout_err <= 1'b1;
          end
        end
        HOLD: begin
          if (out_free) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Overflow buffer for a captured bundle while the output slot is busy.
  always_ff @(posedge CLK) begin
    if (capture && !out_free) hold_bundle <= capture_bundle;
  end

  vop_out_reg u_out_reg (
    .clk         (CLK),
    .rst_n       (nRST),
    .flush       (flush),
    .load        (load),
    .load_bundle (load_bundle),
    .ready       (ex_ready),
    .valid       (ex_valid),
    .bundle      (out_bundle),
    .free        (out_free)
  );

  assign ex_v1    = out_bundle.v1;
  assign ex_v2    = out_bundle.v2;
  assign ex_vmask = out_bundle.vmask;
  assign ex_vd    = out_bundle.vd;
  assign ex_tag   = out_bundle.tag;

endmodule

// File: tb/tb_vector_operand_collector.sv
// Bench for the vector operand collector: directed table, hand sequences for
// backpressure/flush/reset, then randomized traffic against a reference model.
module tb_vector_operand_collector;

  localparam int A_W = 8;
  localparam int V_W = 512;
  localparam int T_W = 4;

  logic           CLK, nRST;
  logic           iss_valid, iss_ready, iss_vm;
  logic [A_W-1:0] iss_vs1, iss_vs2, iss_vd;
  logic [T_W-1:0] iss_tag;
  logic           flush;
  logic           rf_ren, rf_vm, rf_ready, rf_conflict;
  logic [A_W-1:0] rf_vs1, rf_vs2;
  logic [V_W-1:0] rf_v1, rf_v2, rf_vmask;
  logic           ex_valid, ex_ready;
  logic [V_W-1:0] ex_v1, ex_v2, ex_vmask;
  logic [A_W-1:0] ex_vd;
  logic [T_W-1:0] ex_tag;
  logic           timeout_err;
  logic [15:0]    stall_cnt;

  vector_operand_collector dut (
    .CLK(CLK), .nRST(nRST),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_vs1(iss_vs1), .iss_vs2(iss_vs2), .iss_vd(iss_vd),
    .iss_vm(iss_vm), .iss_tag(iss_tag), .flush(flush),
    .rf_ren(rf_ren), .rf_vs1(rf_vs1), .rf_vs2(rf_vs2), .rf_vm(rf_vm),
    .rf_ready(rf_ready), .rf_conflict(rf_conflict),
    .rf_v1(rf_v1), .rf_v2(rf_v2), .rf_vmask(rf_vmask),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_v1(ex_v1), .ex_v2(ex_v2), .ex_vmask(ex_vmask),
    .ex_vd(ex_vd), .ex_tag(ex_tag),
    .timeout_err(timeout_err), .stall_cnt(stall_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Register file model: contents fixed per run, mask pattern per instruction.
  logic [V_W-1:0] mem [256];
  logic [V_W-1:0] cur_pat;
  assign rf_v1    = mem[rf_vs1];
  assign rf_v2    = mem[rf_vs2];
  assign rf_vmask = cur_pat;

  int n_pass, n_total;

  typedef struct {
    logic [V_W-1:0] v1, v2, vmask;
    logic [7:0]     vd;
    logic [3:0]     tag;
  } exp_t;

  typedef struct {
    logic [7:0] vs1, vs2, vd;
    logic       vm;
    logic [3:0] tag;
    int         stalls;
    int         exp_lat;
    int         exp_stall;
    int         exp_to;
  } vec_t;

  task automatic chk_n(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic chk_v(input string name, input logic [V_W-1:0] act, input logic [V_W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [V_W-1:0] rand_vec();
    logic [V_W-1:0] r;
    for (int i = 0; i < V_W / 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  // Expected bundle straight from the operand rules.
  function automatic exp_t model(input logic [7:0] vs1, input logic [7:0] vs2,
                                 input logic [7:0] vd, input logic vm,
                                 input logic [3:0] tag, input logic [V_W-1:0] pat);
    exp_t m;
    m.v1    = (vs1 == 8'd0) ? '0 : mem[vs1];
    m.v2    = (vs2 == 8'd0) ? '0 : mem[vs2];
    m.vmask = vm ? pat : {V_W{1'b1}};
    m.vd    = vd;
    m.tag   = tag;
    return m;
  endfunction

  task automatic check_bundle(input string pfx, input exp_t e);
    chk_v({pfx, "_v1"}, ex_v1, e.v1);
    chk_v({pfx, "_v2"}, ex_v2, e.v2);
    chk_v({pfx, "_vmask"}, ex_vmask, e.vmask);
    chk_n({pfx, "_vd"}, int'(ex_vd), int'(e.vd));
    chk_n({pfx, "_tag"}, int'(ex_tag), int'(e.tag));
  endtask

  task automatic do_reset();
    nRST = 1'b0; iss_valid = 1'b0; flush = 1'b0; rf_ready = 1'b0;
    rf_conflict = 1'b0; ex_ready = 1'b0; iss_vm = 1'b0;
    iss_vs1 = '0; iss_vs2 = '0; iss_vd = '0; iss_tag = '0;
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic issue(input logic [7:0] vs1, input logic [7:0] vs2,
                       input logic [7:0] vd, input logic vm, input logic [3:0] tag);
    iss_valid = 1'b1; iss_vs1 = vs1; iss_vs2 = vs2; iss_vd = vd; iss_vm = vm; iss_tag = tag;
  endtask

  // One table entry: issue at cycle 0, withhold rf_ready for v.stalls cycles.
  task automatic run_vec(input vec_t v);
    int   cyc;
    int   st;
    logic seen;
    do_reset();
    cur_pat = {32{16'hA5A5}};
    ex_ready = 1'b1;
    issue(v.vs1, v.vs2, v.vd, v.vm, v.tag);
    #1 chk_n("iss_ready_idle", int'(iss_ready), 1);
    @(negedge CLK);
    iss_valid = 1'b0;
    cyc = 1;
    seen = 1'b0;
    while (cyc < 20 && !seen) begin
      rf_ready    = (cyc - 1 >= v.stalls);
      rf_conflict = !rf_ready;
      #1;
      if (ex_valid) begin
        seen = 1'b1;
        chk_n("latency", cyc, v.exp_lat);
        chk_n("rf_ren_drop", int'(rf_ren), 0);
        check_bundle("vec", model(v.vs1, v.vs2, v.vd, v.vm, v.tag, cur_pat));
      end else begin
        st = (cyc - 1 < v.stalls) ? cyc - 1 : v.stalls;
        chk_n("rf_ren_req", int'(rf_ren), 1);
        chk_n("rf_vs1_hold", int'(rf_vs1), int'(v.vs1));
        chk_n("rf_vs2_hold", int'(rf_vs2), int'(v.vs2));
        chk_n("rf_vm", int'(rf_vm), int'(v.vm));
        chk_n("stall_cnt_run", int'(stall_cnt), st);
        chk_n("timeout_run", int'(timeout_err), (st >= 4) ? 1 : 0);
      end
      @(negedge CLK);
      cyc++;
    end
    if (!seen) chk_n("ex_valid_wait", 0, 1);
    chk_n("stall_cnt_final", int'(stall_cnt), v.exp_stall);
    chk_n("timeout_final", int'(timeout_err), v.exp_to);
    rf_ready = 1'b0; rf_conflict = 1'b0;
    #1 chk_n("ex_valid_drained", int'(ex_valid), 0);
  endtask

  vec_t tbl[7];
  exp_t q[$];

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    exp_t ea, eb, got_e;
    logic [7:0]     p_vs1, p_vs2, p_vd, f_vs1, f_vs2;
    logic           p_vm, f_vm, pending, prev_hold;
    logic [3:0]     p_tag, snap_tag;
    logic [7:0]     snap_vd;
    logic [V_W-1:0] p_pat, snap_v1;
    int             issued, got, rcyc;

    n_pass = 0; n_total = 0;
    for (int i = 0; i < 256; i++) mem[i] = rand_vec();
    cur_pat = '0;

    //              vs1    vs2    vd      vm    tag  st lat stall to
    tbl[0] = '{8'd5,  8'd9, 8'd3,   1'b0, 4'd2,  0, 2, 0, 0};
    tbl[1] = '{8'd4,  8'd8, 8'd7,   1'b1, 4'd5,  1, 3, 1, 0};
    tbl[2] = '{8'd10, 8'd0, 8'd1,   1'b1, 4'd9,  0, 2, 0, 0};
    tbl[3] = '{8'd0,  8'd0, 8'd255, 1'b0, 4'd15, 0, 2, 0, 0};
    tbl[4] = '{8'd6,  8'd7, 8'd2,   1'b1, 4'd3,  3, 5, 3, 0};
    tbl[5] = '{8'd6,  8'd7, 8'd2,   1'b1, 4'd3,  5, 7, 5, 1};
    tbl[6] = '{8'd20, 8'd21, 8'd22, 1'b0, 4'd4,  4, 6, 4, 1};

    // Reset state
    nRST = 1'b0; iss_valid = 1'b0; flush = 1'b0; rf_ready = 1'b0;
    rf_conflict = 1'b0; ex_ready = 1'b0; iss_vm = 1'b0;
    iss_vs1 = '0; iss_vs2 = '0; iss_vd = '0; iss_tag = '0;
    #12;
    chk_n("rst_iss_ready", int'(iss_ready), 0);
    chk_n("rst_rf_ren", int'(rf_ren), 0);
    chk_n("rst_rf_vs1", int'(rf_vs1), 0);
    chk_n("rst_ex_valid", int'(ex_valid), 0);
    chk_v("rst_ex_v1", ex_v1, '0);
    chk_n("rst_ex_tag", int'(ex_tag), 0);
    chk_n("rst_timeout", int'(timeout_err), 0);
    chk_n("rst_stall_cnt", int'(stall_cnt), 0);

    for (int i = 0; i < 7; i++) run_vec(tbl[i]);

    // Flush keeps the sticky error and the stall count from the last entry.
    flush = 1'b1;
    @(negedge CLK);
    flush = 1'b0;
    #1;
    chk_n("flush_keeps_timeout", int'(timeout_err), 1);
    chk_n("flush_keeps_stall", int'(stall_cnt), 4);

    // Backpressure: first bundle held three cycles, second follows in order.
    do_reset();
    cur_pat = rand_vec();
    ex_ready = 1'b0; rf_ready = 1'b1;
    ea = model(8'd11, 8'd12, 8'd21, 1'b1, 4'd1, cur_pat);
    eb = model(8'd13, 8'd14, 8'd22, 1'b0, 4'd2, cur_pat);
    issue(8'd11, 8'd12, 8'd21, 1'b1, 4'd1);
    @(negedge CLK);
    issue(8'd13, 8'd14, 8'd22, 1'b0, 4'd2);
    #1 chk_n("bp_iss_ready_req", int'(iss_ready), 0);
    for (int c = 2; c <= 4; c++) begin
      @(negedge CLK);
      #1;
      chk_n("bp_ex_valid", int'(ex_valid), 1);
      chk_n("bp_iss_ready_full", int'(iss_ready), 0);
      check_bundle("bp_first", ea);
    end
    @(negedge CLK);
    ex_ready = 1'b1;
    #1 chk_n("bp_iss_ready_drain", int'(iss_ready), 1);
    @(negedge CLK);
    iss_valid = 1'b0;
    #1;
    chk_n("bp_gap_ex_valid", int'(ex_valid), 0);
    chk_n("bp_second_req", int'(rf_ren), 1);
    @(negedge CLK);
    #1;
    chk_n("bp_second_valid", int'(ex_valid), 1);
    check_bundle("bp_second", eb);

    // Flush during REQ: request dropped, later rf_ready ignored.
    do_reset();
    ex_ready = 1'b1; rf_ready = 1'b0;
    issue(8'd3, 8'd4, 8'd5, 1'b1, 4'd6);
    @(negedge CLK);
    iss_valid = 1'b0;
    #1 chk_n("fl_rf_ren", int'(rf_ren), 1);
    @(negedge CLK);
    flush = 1'b1;
    #1 chk_n("fl_iss_ready_flush", int'(iss_ready), 0);
    @(negedge CLK);
    flush = 1'b0;
    rf_ready = 1'b1;
    #1;
    chk_n("fl_rf_ren_off", int'(rf_ren), 0);
    chk_n("fl_ex_valid", int'(ex_valid), 0);
    chk_n("fl_iss_ready_after", int'(iss_ready), 1);
    chk_n("fl_stall_kept", int'(stall_cnt), 1);
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      #1 chk_n("fl_rf_ready_ignored", int'(ex_valid), 0);
    end

    // Flush with a bundle waiting in the output register.
    do_reset();
    ex_ready = 1'b0; rf_ready = 1'b1;
    issue(8'd30, 8'd31, 8'd32, 1'b0, 4'd7);
    @(negedge CLK);
    iss_valid = 1'b0;
    @(negedge CLK);
    #1 chk_n("fl2_ex_valid_before", int'(ex_valid), 1);
    flush = 1'b1;
    @(negedge CLK);
    flush = 1'b0;
    #1;
    chk_n("fl2_ex_valid_after", int'(ex_valid), 0);
    chk_n("fl2_iss_ready", int'(iss_ready), 1);

    // Reset in the middle of a request emits nothing.
    do_reset();
    ex_ready = 1'b1; rf_ready = 1'b0;
    issue(8'd40, 8'd41, 8'd42, 1'b1, 4'd8);
    @(negedge CLK);
    iss_valid = 1'b0;
    #1 chk_n("mr_rf_ren", int'(rf_ren), 1);
    #2 nRST = 1'b0;
    #1;
    chk_n("mr_rf_ren_async", int'(rf_ren), 0);
    chk_n("mr_ex_valid_async", int'(ex_valid), 0);
    @(negedge CLK);
    nRST = 1'b1;
    rf_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      #1 chk_n("mr_no_bundle", int'(ex_valid), 0);
    end

    // Randomized traffic against the queue model.
    do_reset();
    pending = 1'b0; prev_hold = 1'b0;
    issued = 0; got = 0; rcyc = 0;
    f_vs1 = '0; f_vs2 = '0; f_vm = 1'b0;
    p_vs1 = '0; p_vs2 = '0; p_vd = '0; p_vm = 1'b0; p_tag = '0; p_pat = '0;
    snap_tag = '0; snap_vd = '0; snap_v1 = '0;
    while (got < 150 && rcyc < 5000) begin
      @(negedge CLK);
      rcyc++;
      if (prev_hold) begin
        chk_n("rnd_stable_tag", int'(ex_tag), int'(snap_tag));
        chk_n("rnd_stable_vd", int'(ex_vd), int'(snap_vd));
        chk_v("rnd_stable_v1", ex_v1, snap_v1);
      end
      if (!pending && issued < 150 && $urandom_range(0, 9) < 7) begin
        p_vs1 = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
        p_vs2 = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
        p_vd  = 8'($urandom_range(0, 255));
        p_vm  = 1'($urandom_range(0, 1));
        p_tag = 4'($urandom_range(0, 15));
        p_pat = rand_vec();
        pending = 1'b1;
      end
      iss_valid   = pending;
      iss_vs1 = p_vs1; iss_vs2 = p_vs2; iss_vd = p_vd; iss_vm = p_vm; iss_tag = p_tag;
      ex_ready    = ($urandom_range(0, 3) != 0);
      rf_ready    = ($urandom_range(0, 2) != 0);
      rf_conflict = !rf_ready && ($urandom_range(0, 1) != 0);
      #1;
      if (rf_ren) begin
        chk_n("rnd_rf_vs1", int'(rf_vs1), int'(f_vs1));
        chk_n("rnd_rf_vs2", int'(rf_vs2), int'(f_vs2));
        chk_n("rnd_rf_vm", int'(rf_vm), int'(f_vm));
      end
      if (ex_valid && ex_ready) begin
        if (q.size() == 0) begin
          chk_n("rnd_unexpected_bundle", 1, 0);
        end else begin
          got_e = q.pop_front();
          check_bundle("rnd", got_e);
        end
        got++;
      end
      if (iss_valid && iss_ready) begin
        q.push_back(model(p_vs1, p_vs2, p_vd, p_vm, p_tag, p_pat));
        f_vs1 = p_vs1; f_vs2 = p_vs2; f_vm = p_vm;
        cur_pat = p_pat;
        pending = 1'b0;
        issued++;
      end
      prev_hold = ex_valid && !ex_ready;
      snap_tag = ex_tag; snap_vd = ex_vd; snap_v1 = ex_v1;
    end
    chk_n("rnd_delivered", got, 150);
    chk_n("rnd_queue_empty", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
